// File: rtl/bw_io_dtl_rcv_filt_if.sv
// Signal bundle between the DTL receive filter and its consumer.
//   rcv_in, filt_en, clr           : driven by master, sampled by the filter
//   dout, rise_p, fall_p, evt_cnt,
//   glitch_seen, stable            : driven by the filter (slave)
interface bw_io_dtl_rcv_filt_if #(
  parameter int EVT_W = 8
);
  logic             rcv_in;
  logic             filt_en;
  logic             clr;
  logic             dout;
  logic             rise_p;
  logic             fall_p;
  logic [EVT_W-1:0] evt_cnt;
  logic             glitch_seen;
  logic             stable;

  modport master (
    output rcv_in, filt_en, clr,
    input  dout, rise_p, fall_p, evt_cnt, glitch_seen, stable
  );

  modport slave (
    input  rcv_in, filt_en, clr,
    output dout, rise_p, fall_p, evt_cnt, glitch_seen, stable
  );
endinterface

// File: rtl/bw_io_dtl_rcv_filt.sv
// DTL/HSTL receiver conditioning: resynchronises the receiver output into
// the core clock domain, rejects pulses shorter than FILT_CNT samples, and
// reports the clean level with edge strobes, a saturating edge counter and a
// sticky glitch flag.
// Ports:
//   clk       core clock, posedge
//   rst       asynchronous active-high reset
//   io.rcv_in receiver output (async), io.filt_en filter enable (0 = bypass)
//   io.clr    sync clear of evt_cnt / glitch_seen
//   io.dout   filtered level, io.rise_p / io.fall_p one-cycle edge strobes
//   io.evt_cnt saturating edge count, io.glitch_seen sticky abort flag
//   io.stable filter idle (no candidate pending)
module bw_io_dtl_rcv_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 4,
  parameter int CNT_W       = 4,
  parameter int EVT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  bw_io_dtl_rcv_filt_if.slave   io
);
  // Encoding chosen so bit1 is the output level and bit1==bit0 means idle.
  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    CHK_HI  = 2'b01,
    IDLE_HI = 2'b11,
    CHK_LO  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   abort;
  logic                   rise, fall;
  logic                   rise_q, fall_q, glitch_q;
  logic [EVT_W-1:0]       evt_q;

  // Plain flop chain, nothing between stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], io.rcv_in};
  end
  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE_LO;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    abort     = 1'b0;
    if (!io.filt_en) begin
      // Bypass: follow the synchroniser; any pending candidate is dropped
      // silently.
      state_nxt = sync ? IDLE_HI : IDLE_LO;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE_LO: if (sync) begin
          if (FILT_CNT == 1) state_nxt = IDLE_HI;
          else begin
            state_nxt = CHK_HI;
            cnt_nxt   = CNT_W'(1);
          end
        end
        CHK_HI: begin
          if (!sync) begin
            state_nxt = IDLE_LO;
            cnt_nxt   = '0;
            abort     = 1'b1;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE_HI;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        IDLE_HI: if (!sync) begin
          if (FILT_CNT == 1) state_nxt = IDLE_LO;
          else begin
            state_nxt = CHK_LO;
            cnt_nxt   = CNT_W'(1);
          end
        end
        CHK_LO: begin
          if (sync) begin
            state_nxt = IDLE_HI;
            cnt_nxt   = '0;
            abort     = 1'b1;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE_LO;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE_LO;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Level changes are visible one edge ahead in state_nxt[1], so strobes are
  // registered alongside the new dout.
  assign rise = ~state[1] &  state_nxt[1];
  assign fall =  state[1] & ~state_nxt[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      evt_q    <= '0;
      glitch_q <= 1'b0;
    end else begin
      rise_q <= rise;
      fall_q <= fall;
      // clr takes priority over a coincident event or abort.
      if (io.clr)                           evt_q <= '0;
      else if ((rise | fall) && evt_q != '1) evt_q <= evt_q + EVT_W'(1);
      if (io.clr)     glitch_q <= 1'b0;
      else if (abort) glitch_q <= 1'b1;
    end
  end

  assign io.dout        = state[1];
  assign io.stable      = state[1] ~^ state[0];
  assign io.rise_p      = rise_q;
  assign io.fall_p      = fall_q;
  assign io.evt_cnt     = evt_q;
  assign io.glitch_seen = glitch_q;
endmodule

// File: tb/tb_bw_io_dtl_rcv_filt.sv
module tb_bw_io_dtl_rcv_filt;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   t0;

  typedef struct {bit pol; int at;} ev_t;
  ev_t q0[$];
  ev_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bw_io_dtl_rcv_filt_if #(.EVT_W(8)) if0 ();
  bw_io_dtl_rcv_filt_if #(.EVT_W(8)) if1 ();

  bw_io_dtl_rcv_filt #(.SYNC_STAGES(2), .FILT_CNT(4), .CNT_W(4), .EVT_W(8)) u_dut0 (
    .clk (clk), .rst (rst), .io (if0.slave)
  );
  bw_io_dtl_rcv_filt #(.SYNC_STAGES(2), .FILT_CNT(1), .CNT_W(4), .EVT_W(8)) u_dut1 (
    .clk (clk), .rst (rst), .io (if1.slave)
  );

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboards: each strobe must match the oldest expected event.
  always @(negedge clk) begin
    ev_t ev;
    if (if0.rise_p | if0.fall_p) begin
      chk("d0_strobe_excl", if0.rise_p & if0.fall_p, 0);
      chk("d0_evt_expected", q0.size() != 0, 1);
      if (q0.size() != 0) begin
        ev = q0.pop_front();
        chk("d0_evt_edge", cyc, ev.at);
        chk("d0_evt_pol", if0.rise_p, ev.pol);
        chk("d0_evt_dout", if0.dout, ev.pol);
      end
    end
  end

  always @(negedge clk) begin
    ev_t ev;
    if (if1.rise_p | if1.fall_p) begin
      chk("d1_strobe_excl", if1.rise_p & if1.fall_p, 0);
      chk("d1_evt_expected", q1.size() != 0, 1);
      if (q1.size() != 0) begin
        ev = q1.pop_front();
        chk("d1_evt_edge", cyc, ev.at);
        chk("d1_evt_pol", if1.rise_p, ev.pol);
        chk("d1_evt_dout", if1.dout, ev.pol);
      end
    end
  end

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic step0(input bit v, input int lat);
    int ts;
    ts = cyc;
    if0.rcv_in = v;
    q0.push_back(ev_t'{v, ts + lat});
    wait_to(ts + lat + 4);
  endtask

  initial begin
    rst = 1'b1;
    if0.rcv_in = 1'b0; if0.filt_en = 1'b1; if0.clr = 1'b0;
    if1.rcv_in = 1'b0; if1.filt_en = 1'b1; if1.clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", if0.dout, 0);
    chk("rst_rise", if0.rise_p, 0);
    chk("rst_fall", if0.fall_p, 0);
    chk("rst_evt", if0.evt_cnt, 0);
    chk("rst_glitch", if0.glitch_seen, 0);
    chk("rst_stable", if0.stable, 1);
    rst = 1'b0;
    @(negedge clk);

    // Clean 0->1 step: dout on edge 6, busy on edges 3..5.
    t0 = cyc;
    if0.rcv_in = 1'b1;
    q0.push_back(ev_t'{1'b1, t0 + 6});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("step_stable", if0.stable, !(k >= 3 && k <= 5));
      chk("step_dout", if0.dout, k >= 6);
    end
    chk("step_evt", if0.evt_cnt, 1);

    if0.clr = 1'b1;
    @(negedge clk);
    if0.clr = 1'b0;
    chk("clr_evt", if0.evt_cnt, 0);

    step0(1'b0, 6);
    chk("fall_evt", if0.evt_cnt, 1);

    // 3-sample pulse must be rejected.
    if0.rcv_in = 1'b1;
    repeat (3) @(negedge clk);
    if0.rcv_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("pulse_dout", if0.dout, 0);
    chk("pulse_glitch", if0.glitch_seen, 1);
    chk("pulse_evt", if0.evt_cnt, 1);
    chk("pulse_stable", if0.stable, 1);

    step0(1'b1, 6);
    step0(1'b0, 6);
    step0(1'b1, 6);
    step0(1'b0, 6);
    chk("pre_clr_evt", if0.evt_cnt, 5);

    // clr on the same edge as the rise event: clr wins, strobe still fires.
    t0 = cyc;
    if0.rcv_in = 1'b1;
    q0.push_back(ev_t'{1'b1, t0 + 6});
    wait_to(t0 + 5);
    if0.clr = 1'b1;
    @(negedge clk);
    if0.clr = 1'b0;
    chk("clrev_evt", if0.evt_cnt, 0);
    chk("clrev_dout", if0.dout, 1);
    chk("clrev_glitch", if0.glitch_seen, 0);
    @(negedge clk);
    chk("clrev_drop", if0.evt_cnt, 0);
    wait_to(t0 + 10);

    // Async reset mid CHK_HI (cnt=2), then full re-qualification.
    step0(1'b0, 6);
    t0 = cyc;
    if0.rcv_in = 1'b1;
    q0.push_back(ev_t'{1'b1, t0 + 6});
    wait_to(t0 + 4);
    chk("mid_stable", if0.stable, 0);
    chk("mid_evt", if0.evt_cnt, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_dout", if0.dout, 0);
    chk("arst_stable", if0.stable, 1);
    chk("arst_evt", if0.evt_cnt, 0);
    chk("arst_rise", if0.rise_p, 0);
    chk("arst_glitch", if0.glitch_seen, 0);
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    t0 = cyc;
    q0.push_back(ev_t'{1'b1, t0 + 6});
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("rq_dout", if0.dout, k >= 6);
    end
    chk("rq_evt", if0.evt_cnt, 1);
    chk("rq_glitch", if0.glitch_seen, 0);

    // Dropping filt_en mid CHK_LO: level follows sync, no glitch.
    t0 = cyc;
    if0.rcv_in = 1'b0;
    q0.push_back(ev_t'{1'b0, t0 + 5});
    wait_to(t0 + 4);
    chk("fen_busy", if0.stable, 0);
    if0.filt_en = 1'b0;
    wait_to(t0 + 8);
    chk("fen_glitch", if0.glitch_seen, 0);
    chk("fen_dout", if0.dout, 0);
    chk("fen_stable", if0.stable, 1);
    chk("fen_evt", if0.evt_cnt, 2);

    // Bypass toggling: 3-edge latency, counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      t0 = cyc;
      if0.rcv_in = ~if0.rcv_in;
      q0.push_back(ev_t'{bit'(if0.rcv_in), t0 + 3});
      repeat (4) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("sat_evt", if0.evt_cnt, 255);
    chk("sat_glitch", if0.glitch_seen, 0);
    if0.filt_en = 1'b1;

    // FILT_CNT=1 instance: 1->0 step falls on edge 3.
    t0 = cyc;
    if1.rcv_in = 1'b1;
    q1.push_back(ev_t'{1'b1, t0 + 3});
    wait_to(t0 + 6);
    t0 = cyc;
    if1.rcv_in = 1'b0;
    q1.push_back(ev_t'{1'b0, t0 + 3});
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("f1_dout", if1.dout, k < 3);
    end
    chk("f1_glitch", if1.glitch_seen, 0);
    chk("f1_evt", if1.evt_cnt, 2);

    repeat (2) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bw_io_dtl_rcv_filt.md
Name: bw_io_dtl_rcv_filt

Overview:
Digital conditioning stage directly downstream of the DTL/HSTL receiver sense amp. It takes the receiver's registered output, resynchronises it into the core clock domain, and rejects pulses shorter than a programmable number of samples. It produces a clean level with single-cycle rise/fall strobes, a saturating edge counter, and a sticky glitch flag for pad characterisation and debug.

Parameters:
SYNC_STAGES, 2, synchroniser depth in flops (legal >= 2)
FILT_CNT, 4, consecutive matching samples needed to accept a new level (legal 1..2**CNT_W-1)
CNT_W, 4, width of the internal debounce counter
EVT_W, 8, width of the edge event counter

Ports:
clk  input  1  core clock; all flops on posedge
rst  input  1  asynchronous, active-high reset
rcv_in  input  1  receiver output (out of the receiver), asynchronous to clk
filt_en  input  1  1 = debounce filter active; 0 = bypass (level follows synchroniser)
clr  input  1  synchronous clear of evt_cnt and glitch_seen
dout  output  1  filtered level
rise_p  output  1  one-cycle strobe on dout 0->1
fall_p  output  1  one-cycle strobe on dout 1->0
evt_cnt  output  EVT_W  count of accepted edges, saturating
glitch_seen  output  1  sticky: a candidate transition was aborted
stable  output  1  filter in an idle state (no transition pending)

Behaviour:
- Reset (async, immediate): sync chain all 0, state IDLE_LO, debounce cnt 0, dout 0, rise_p 0, fall_p 0, evt_cnt 0, glitch_seen 0, stable 1. Reset mid-transition discards the pending candidate.
- Synchroniser: SYNC_STAGES flops, reset 0; sync = last stage. No logic between stages.
- FSM states: IDLE_LO, CHK_HI, IDLE_HI, CHK_LO. dout is 1 in IDLE_HI and CHK_LO, 0 otherwise, and is registered.
- IDLE_LO: sync=1 -> if FILT_CNT=1 go IDLE_HI, else go CHK_HI with cnt=1.
- CHK_HI: sync=1 and cnt==FILT_CNT-1 -> IDLE_HI, cnt=0. sync=1 otherwise -> cnt+1. sync=0 -> IDLE_LO, cnt=0, set glitch_seen.
- IDLE_HI / CHK_LO: mirror images of the above, with polarity inverted.
- Latency: for a clean step on rcv_in set up before edge 1, dout changes on edge SYNC_STAGES+FILT_CNT. The defaults give edge 6.
- Bypass (filt_en=0): each edge, the state goes to IDLE_HI if sync=1, else IDLE_LO; cnt=0; glitch_seen is not set. dout latency is SYNC_STAGES+1 edges. Toggling filt_en mid-CHK aborts the candidate without setting glitch_seen.
- rise_p / fall_p: asserted in the cycle after the edge on which dout changes, for exactly one cycle. They are never both high.
- evt_cnt: +1 on every rise_p or fall_p event. It holds at all-ones (saturates) and does not wrap.
- clr: on the next edge, evt_cnt=0 and glitch_seen=0. If clr coincides with an edge event or a glitch abort, clr wins: the result is 0 and the event is dropped. clr does not affect the FSM, dout, or the strobes.
- stable = 1 in IDLE_LO/IDLE_HI; 0 in CHK_*.
- Width rules: cnt compares against FILT_CNT-1 at CNT_W bits. Behaviour for FILT_CNT outside its legal range is not required.

Test Plan:
- Reset then a clean 0->1 step on rcv_in (defaults, filt_en=1) -> dout=1 on edge 6; rise_p high for exactly one cycle; evt_cnt=1; stable low during edges 3-5.
- 3-cycle high pulse on rcv_in (FILT_CNT=4) -> dout stays 0; no rise_p; glitch_seen=1; evt_cnt unchanged; stable returns to 1.
- filt_en=0, rcv_in toggles every 4 cycles for 300 edges -> dout follows with a 3-edge latency; evt_cnt saturates at 255 and holds.
- clr asserted on the same edge as a rise event with evt_cnt=5 -> evt_cnt=0 afterwards, dout=1, rise_p still pulses once.
- rst asserted mid CHK_HI (cnt=2) -> all outputs take their reset values without a clock edge; after release, the input must be re-qualified from zero (full SYNC_STAGES+FILT_CNT latency).
- FILT_CNT=1, then a 1->0 step -> dout falls on edge 3; fall_p pulses once; glitch_seen stays 0.
